// File: rtl/seg_scan_ctrl_pkg.sv
// Shared constants, types and hex segment table for the scan controller.
// Segment bits are a..g with [0] = a.
package seg_scan_ctrl_pkg;

  localparam int NDIG = 4;

  localparam logic [3:0] AN_OFF  = 4'hF;
  localparam logic [6:0] SEG_OFF = 7'h7F;

  // Active-high a..g, entry 15 first.
  localparam logic [15:0][6:0] HEX_SEG = {
    7'h71, 7'h79, 7'h5E, 7'h39,
    7'h7C, 7'h77, 7'h6F, 7'h7F,
    7'h07, 7'h7D, 7'h6D, 7'h66,
    7'h4F, 7'h5B, 7'h06, 7'h3F
  };

  typedef enum logic {
    SL_BLANK,
    SL_DRIVE
  } slot_e;

  typedef struct packed {
    logic [15:0] value;
    logic [3:0]  blank;
    logic [3:0]  dp;
  } disp_t;

endpackage

// File: rtl/seg_scan_ctrl_if.sv
// Update handshake bundle: upd_valid/upd_ready plus value, blank, dp.
// master = requester, slave = scan controller.
interface seg_scan_ctrl_if;

  logic        upd_valid;
  logic        upd_ready;
  logic [15:0] value;
  logic [3:0]  blank;
  logic [3:0]  dp;

  modport master (
    output upd_valid, value, blank, dp,
    input  upd_ready
  );

  modport slave (
    input  upd_valid, value, blank, dp,
    output upd_ready
  );

endinterface

// File: rtl/seg_scan_ctrl_hex.sv
// seg_hex_decode: nibble -> active-high a..g segments.
// Ports: nib (4-bit in), seg (7-bit out).
module seg_hex_decode
  import seg_scan_ctrl_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nib];

endmodule

// File: rtl/seg_scan_ctrl.sv
// Four-digit common-anode seven-segment scan controller.
// Ports: clk, rst_n, en, upd (slave), anode, light, dp_n, frame_done.
module seg_scan_ctrl
  import seg_scan_ctrl_pkg::*;
#(
  parameter int PRESCALER = 50000,
  parameter int GUARD     = 16
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            en,
  seg_scan_ctrl_if.slave  upd,
  output logic [3:0]      anode,
  output logic [6:0]      light,
  output logic            dp_n,
  output logic            frame_done
);

  localparam int CW = $clog2(PRESCALER);
  localparam logic [CW-1:0] CMAX = CW'(PRESCALER - 1);
  localparam logic [CW-1:0] GEND = CW'(GUARD);
  localparam slot_e ST_RST =
    (GUARD > 0) ? SL_BLANK : SL_DRIVE;

  logic [CW-1:0] cnt, cnt_nxt;
  logic [1:0]    idx, idx_nxt;
  slot_e         st, st_nxt;

  disp_t pend, shadow;
  logic  pend_full;
  logic  bnd, commit, take;

  logic [6:0] seg;
  logic [3:0] an_nxt;
  logic [6:0] light_nxt;
  logic       dpn_nxt;

  seg_hex_decode u_dec (
    .nib (shadow.value[{idx, 2'b00} +: 4]),
    .seg (seg)
  );

  assign bnd    = en && (cnt == CMAX)
                  && (idx == 2'd3);
  assign commit = pend_full && (bnd || !en);
  assign take   = upd.upd_valid && !pend_full;

  assign upd.upd_ready = !pend_full;

  // Timebase and slot state; st mirrors
  // cnt < GUARD one cycle ahead.
  always_comb begin
    cnt_nxt = '0;
    idx_nxt = '0;
    if (en) begin
      if (cnt == CMAX) begin
        cnt_nxt = '0;
        idx_nxt = idx + 2'd1;
      end else begin
        cnt_nxt = cnt + 1'b1;
        idx_nxt = idx;
      end
    end
    st_nxt = (cnt_nxt < GEND)
             ? SL_BLANK : SL_DRIVE;
  end

  // Pin values for next cycle.
  always_comb begin
    an_nxt    = AN_OFF;
    light_nxt = SEG_OFF;
    dpn_nxt   = 1'b1;
    unique case (st)
      SL_BLANK: ;
      SL_DRIVE: begin
        if (en && !shadow.blank[idx]) begin
          an_nxt[idx] = 1'b0;
          light_nxt   = ~seg;
          dpn_nxt     = ~shadow.dp[idx];
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt        <= '0;
      idx        <= '0;
      st         <= ST_RST;
      anode      <= AN_OFF;
      light      <= SEG_OFF;
      dp_n       <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      cnt        <= cnt_nxt;
      idx        <= idx_nxt;
      st         <= st_nxt;
      anode      <= an_nxt;
      light      <= light_nxt;
      dp_n       <= dpn_nxt;
      frame_done <= bnd;
    end
  end

  // Pending commits only at a frame
  // boundary, or at once while dark.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pend_full    <= 1'b0;
      pend         <= '0;
      shadow.value <= 16'h0000;
      shadow.blank <= 4'hF;
      shadow.dp    <= 4'h0;
    end else if (commit) begin
      shadow    <= pend;
      pend_full <= 1'b0;
    end else if (take) begin
      pend.value <= upd.value;
      pend.blank <= upd.blank;
      pend.dp    <= upd.dp;
      pend_full  <= 1'b1;
    end
  end

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Self-checking bench for seg_scan_ctrl.
// Frame-position model plus directed literal checks.
module tb_seg_scan_ctrl;

  localparam int P  = 8;
  localparam int G  = 2;
  localparam int FL = 4 * P;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       en;
  logic [3:0] anode;
  logic [6:0] light;
  logic       dp_n;
  logic       frame_done;

  seg_scan_ctrl_if u_if ();

  seg_scan_ctrl #(
    .PRESCALER (P),
    .GUARD     (G)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .upd        (u_if.slave),
    .anode      (anode),
    .light      (light),
    .dp_n       (dp_n),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [6:0] seg_tbl [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F,
    7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C,
    7'h39, 7'h5E, 7'h79, 7'h71
  };

  int          m_t  = 0;
  bit          m_pf = 1'b0;
  logic [15:0] m_pv, m_sv;
  logic [3:0]  m_pb, m_pd, m_sb, m_sd;
  logic [3:0]  e_an;
  logic [6:0]  e_li;
  logic        e_dpn, e_fd;
  bit          chk_on = 1'b0;

  task automatic chk(input string nm,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // m_t is the position within the frame
  // (slot*P + count) that the next edge uses.
  always @(posedge clk) begin : model
    int slot, pos;
    bit bnd;
    if (!rst_n) begin
      m_t = 0; m_pf = 1'b0;
      m_sv = 16'h0; m_sb = 4'hF; m_sd = 4'h0;
      e_an = 4'hF; e_li = 7'h7F;
      e_dpn = 1'b1; e_fd = 1'b0;
    end else begin
      slot = m_t / P;
      pos  = m_t % P;
      bnd  = en && (m_t == FL - 1);
      e_an = 4'hF; e_li = 7'h7F;
      e_dpn = 1'b1; e_fd = bnd;
      if (en && pos >= G && !m_sb[slot]) begin
        e_an  = 4'hF;
        e_an[slot] = 1'b0;
        e_li  = ~seg_tbl[m_sv[slot*4 +: 4]];
        e_dpn = ~m_sd[slot];
      end
      m_t = en ? (m_t + 1) % FL : 0;
      if (m_pf && (bnd || !en)) begin
        m_sv = m_pv; m_sb = m_pb; m_sd = m_pd;
        m_pf = 1'b0;
      end else if (u_if.upd_valid && !m_pf) begin
        m_pv = u_if.value; m_pb = u_if.blank;
        m_pd = u_if.dp; m_pf = 1'b1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("anode", anode, e_an);
      chk("light", light, e_li);
      chk("dp_n", dp_n, e_dpn);
      chk("frame_done", frame_done, e_fd);
      chk("upd_ready", u_if.upd_ready, !m_pf);
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic wait_t(input int tgt);
    for (int i = 0; i < 200; i++) begin
      if (m_t == tgt) return;
      @(negedge clk);
    end
    chk("wait_t_timeout", 1, 0);
  endtask

  task automatic wait_fd();
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (frame_done) return;
    end
    chk("wait_fd_timeout", 1, 0);
  endtask

  task automatic send(input logic [15:0] v,
                      input logic [3:0] b,
                      input logic [3:0] d);
    u_if.upd_valid = 1'b1;
    u_if.value = v; u_if.blank = b; u_if.dp = d;
    @(negedge clk);
    u_if.upd_valid = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin : stim
    int first;
    rst_n = 1'b0; en = 1'b0;
    u_if.upd_valid = 1'b0;
    u_if.value = '0; u_if.blank = '0; u_if.dp = '0;
    cyc(2);
    chk_on = 1'b1;
    chk("rst_anode", anode, 4'hF);
    chk("rst_light", light, 7'h7F);
    chk("rst_dp_n", dp_n, 1);
    chk("rst_fd", frame_done, 0);
    chk("rst_ready", u_if.upd_ready, 1);

    // Blank shadow: dark scan, pulse each 32
    rst_n = 1'b1; en = 1'b1;
    first = 0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (frame_done && first == 0) first = k;
    end
    chk("first_fd_cycle", first, 32);

    // Update at reset
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    send(16'h1234, 4'h0, 4'b0100);
    chk("busy_after_xfer", u_if.upd_ready, 0);
    first = 0;
    for (int k = 2; k <= 40; k++) begin
      @(negedge clk);
      if (frame_done && first == 0) first = k;
      if (first != 0) break;
    end
    chk("commit_fd_cycle", first, 32);
    chk("ready_after_bnd", u_if.upd_ready, 1);
    cyc(2);
    chk("slot0_guard", anode, 4'hF);
    cyc(1);
    chk("slot0_anode", anode, 4'b1110);
    chk("slot0_light", light, 7'b0011001);
    cyc(17);
    chk("slot2_dp", dp_n, 0);
    chk("slot2_light", light, 7'b0100100);

    // Update in the boundary cycle, then
    // an ignored FFFF while busy
    wait_t(FL - 1);
    u_if.upd_valid = 1'b1;
    u_if.value = 16'h5678;
    u_if.blank = 4'h0; u_if.dp = 4'h0;
    @(negedge clk);
    chk("bnd_fd", frame_done, 1);
    u_if.value = 16'hFFFF;
    cyc(3);
    chk("old_held", light, 7'b0011001);
    cyc(10);
    u_if.upd_valid = 1'b0;
    wait_fd();
    cyc(3);
    chk("new_8", light, 7'h00);

    // Blanked digits 1 and 3
    send(16'hABCD, 4'b1010, 4'h0);
    wait_fd();
    cyc(3);
    chk("d0_anode", anode, 4'b1110);
    chk("d0_light", light, 7'b0100001);
    cyc(8);
    chk("d1_dark", anode, 4'hF);
    cyc(8);
    chk("d2_anode", anode, 4'b1011);
    chk("d2_light", light, 7'b0000011);
    cyc(8);
    chk("d3_dark", anode, 4'hF);

    // Drop en mid-slot 2 with pending full
    wait_t(1);
    send(16'h9999, 4'h0, 4'h0);
    wait_t(2 * P + 3);
    en = 1'b0;
    @(negedge clk);
    chk("en_off_dark", anode, 4'hF);
    chk("en_off_commit", u_if.upd_ready, 1);
    cyc(2);
    en = 1'b1;
    @(negedge clk);
    chk("restart_guard", anode, 4'hF);
    cyc(2);
    chk("restart_anode", anode, 4'b1110);
    chk("restart_light", light, 7'b0010000);

    // Reset mid-DRIVE with pending full
    wait_t(1);
    send(16'h1111, 4'h0, 4'h0);
    wait_t(5);
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst_mid_anode", anode, 4'hF);
    chk("rst_mid_ready", u_if.upd_ready, 1);
    rst_n = 1'b1;

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      u_if.upd_valid = ($urandom % 3) == 0;
      u_if.value = 16'($urandom);
      u_if.blank = 4'($urandom);
      u_if.dp    = 4'($urandom);
      en    = ($urandom % 50) != 0;
      rst_n = ($urandom % 300) != 0;
    end
    @(negedge clk);
    chk_on = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
- Four-digit time-multiplexed seven-segment scan controller for the board's common-anode display.
- Owns the refresh timebase, the digit sequencing, the per-slot anti-ghosting blanking and the per-digit blank/decimal-point masks.
- Accepts new display contents through a valid/ready handshake and commits them only at frame boundaries, so a frame never mixes old and new digits.
- Drives anode, cathode and decimal-point pins directly.

Parameters:
- PRESCALER, 50000, clk cycles per digit slot; must be >= GUARD+2.
- GUARD, 16, cycles at the start of each slot with all anodes off (anti-ghosting).

Ports:
- clk  input  1  system clock
- rst_n  input  1  synchronous reset, active-low
- en  input  1  scan enable; 0 = display dark, timebase held at zero
- upd_valid  input  1  update request
- upd_ready  output  1  controller can accept an update
- value  input  16  four hex nibbles; [3:0] = digit 0
- blank  input  4  per-digit blank, 1 = digit dark
- dp  input  4  per-digit decimal point, 1 = lit
- anode  output  4  active-low digit enables
- light  output  7  active-low segments a..g, [0] = a
- dp_n  output  1  active-low decimal point
- frame_done  output  1  one-cycle pulse at each frame boundary

Behaviour:
- Reset (rst_n=0 at posedge): anode=4'b1111, light=7'h7F, dp_n=1, frame_done=0, upd_ready=1.
  - Internal state: slot counter=0, digit index=0, pending empty, shadow value=0, shadow blank=4'b1111, shadow dp=0.
- Timebase:
  - cnt runs 0..PRESCALER-1 and wraps to 0.
  - On wrap, idx advances 0→1→2→3→0.
  - Frame boundary = cycle where cnt==PRESCALER-1 and idx==3.
- Slot FSM, two states:
  - BLANK when cnt<GUARD, DRIVE otherwise.
  - BLANK: anode=1111, light=7F, dp_n=1.
  - DRIVE: anode[idx]=0 and all other anode bits 1, unless shadow blank[idx]=1, in which case the outputs are as in BLANK.
  - DRIVE: light = active-low hex decode of shadow nibble idx (0-F full hex set); dp_n = ~shadow dp[idx].
- Output timing:
  - All pin outputs are registered: they reflect the cnt/idx/shadow values of the previous cycle (1-cycle latency).
  - frame_done is registered and high for the cycle after the frame boundary.
- Update handshake:
  - Transfer occurs when upd_valid && upd_ready at a posedge. value/blank/dp are captured into pending, and upd_ready=0 from the next cycle.
  - At a frame boundary with pending full at the start of that cycle: pending→shadow, pending empty, upd_ready=1 next cycle. The new contents are first displayed from digit 0 of the next frame.
  - A transfer in the same cycle as a boundary (pending empty) is held and commits at the following boundary.
  - upd_valid while upd_ready=0 is ignored; there is no overwrite of pending.
  - Requesters must hold their data stable only while upd_valid && !upd_ready.
- en=0:
  - cnt and idx are forced to 0.
  - Outputs are as in BLANK; frame_done=0.
  - A full pending commits to shadow on the next cycle regardless of boundary.
  - The handshake stays operational.
- en 0→1: scanning starts at idx 0, cnt 0, in BLANK.
- Reset mid-frame or mid-handshake: pending is discarded and upd_ready=1 the next cycle.

Decomposition:
- Shared package:
  - digit-count constant (4);
  - active-low blank pattern constants (7'h7F anodes/segments off);
  - 16-entry hex→segment table in active-high a..g order.
- Sub-module seg_hex_decode: combinational 4-bit nibble → 7-bit active-high segments.
  - The controller inverts and registers its output.
- Counter, FSM, pending/shadow registers and handshake stay in seg_scan_ctrl.

Test Plan (PRESCALER=8, GUARD=2):
- Reset then en=1, no update:
  - anode stays 1111 every cycle (shadow blank=1111).
  - frame_done pulses every 32 cycles, first pulse at cycle 32 after en rises.
- Update value=16'h1234, blank=0, dp=4'b0100 at reset:
  - upd_ready=0 until the first boundary.
  - Next frame: slot 0 shows anode=1110, light=~"4" (7'b0011001) for cycles 2..7 after the 2-cycle blank.
  - Slot 2 shows dp_n=0, digit "2".
  - upd_ready returns to 1 the cycle after the boundary.
- Update asserted in the exact boundary cycle:
  - Accepted (ready was 1).
  - Shadow is unchanged for the whole next frame; the new value appears one frame later.
- Second upd_valid while upd_ready=0 with value=16'hFFFF:
  - Ignored; the displayed value is the first update only.
- blank=4'b1010 with value=16'hABCD:
  - Digits 1 and 3 keep anode=1111 through their whole slot.
  - Digits 0/2 show "D"/"B".
- Drop en mid-slot 2 with pending full:
  - Outputs go dark the next cycle and the commit happens the following cycle.
  - On en=1, scanning restarts at idx 0 with a 2-cycle BLANK.
- Assert rst_n=0 mid-DRIVE:
  - All outputs return to their reset values the next cycle and pending is discarded.
